// File: rtl/bambu_tx_arbiter.sv
// bambu_tx_arbiter: round-robin per-byte arbiter sharing one UART TX port among NUM_REQ requesters.
// Define BAMBU_TX_ARB_LINE_LOCK_EN to keep a requester's line together until 8'h0A or an idle timeout.
module bambu_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           TX_DATA,
  output logic                 TX_ENABLE,
  input  logic                 TX_READY,
  output logic                 busy
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_param
    $error("bambu_tx_arbiter: parameter out of range");
  end
  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, win;
  logic [NUM_REQ-1:0] elig, hi, req_ready_q, req_ready_d;
  logic [7:0]         tx_data_q, tx_data_d, win_data;
  logic               tx_enable_q, tx_enable_d, busy_q, busy_d, found, grant, lock_d;
  // Lowest eligible bit at or above ptr wins; otherwise lowest eligible bit overall (wrap).
  always_comb begin
    hi       = elig & ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));
    found    = |elig;
    win      = '0;
    win_data = 8'h00;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (elig[i]) begin
        win      = PW'(i);
        win_data = req_data[8*i +: 8];
      end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (hi[i]) begin
        win      = PW'(i);
        win_data = req_data[8*i +: 8];
      end
  end
  assign grant = state_q == IDLE && TX_READY && found;
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_data_d   = tx_data_q;
    tx_enable_d = 1'b0;
    req_ready_d = '0;
    if (grant) begin
      state_d     = SEND;
      ptr_d       = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
      tx_data_d   = win_data;
      tx_enable_d = 1'b1;
      req_ready_d = NUM_REQ'(1) << win;
    end else if (state_q == SEND) begin
      state_d = GAP;
    end else if (state_q == GAP) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE || lock_d;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tx_data_q   <= tx_data_d;
      tx_enable_q <= tx_enable_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end
`ifdef BAMBU_TX_ARB_LINE_LOCK_EN
  logic          lock_q;
  logic [PW-1:0] owner_q, owner_d;
  logic [15:0]   cnt_q, cnt_d;
  assign elig = lock_q ? req_valid & (NUM_REQ'(1) << owner_q) : req_valid;
  // Idle counter runs only while the owner has nothing pending; a grant restarts it.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant) begin
      cnt_d   = '0;
      lock_d  = 1'b1;
      owner_d = lock_q ? owner_q : win;
    end else if (lock_q && state_q == SEND && tx_data_q == 8'h0A) begin
      lock_d = 1'b0;
    end else if (lock_q && state_q == IDLE && !req_valid[owner_q]) begin
      cnt_d  = cnt_q + 16'd1;
      lock_d = cnt_d != 16'(LOCK_TIMEOUT);
      cnt_d  = lock_d ? cnt_d : '0;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign elig   = req_valid;
  assign lock_d = 1'b0;
`endif
  assign TX_DATA   = tx_data_q;
  assign TX_ENABLE = tx_enable_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_bambu_tx_arbiter.sv
// tb_bambu_tx_arbiter: directed stimulus with a scoreboard of expected {requester, byte} grants.
module tb_bambu_tx_arbiter;
  localparam int NR = 4;
  logic          clock, reset_n, TX_ENABLE, TX_READY, busy;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_valid, req_ready;
  logic [7:0]    TX_DATA;
  int            passed = 0, total = 0, cyc = 0;
  logic [11:0]   sb[$];
  int            st[$];
  logic [7:0]    rq[NR][$];
  int            vcyc[NR];
  logic [11:0]   e;

  bambu_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .TX_DATA(TX_DATA), .TX_ENABLE(TX_ENABLE), .TX_READY(TX_READY), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    else passed++;
  endtask

  task automatic expect_grant(input int idx, input logic [7:0] d);
    sb.push_back({4'(idx), d});
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NR; i++) p |= rq[i].size() != 0;
    return p;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || pending()) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_in_time", 32'(n < budget), 1);
    repeat (6) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    st.delete();
  endtask

  // Requester model: hold each byte until its ready pulse, then present the next one.
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0 && !req_valid[i]) vcyc[i] = cyc;
      req_valid[i] = rq[i].size() > 0;
      if (rq[i].size() > 0) req_data[8*i +: 8] = rq[i][0];
    end
  end

  // Monitor: every strobe or ready pulse must match the next scoreboard entry.
  initial forever begin
    @(negedge clock);
    if (TX_ENABLE || req_ready != '0) begin
      if (TX_ENABLE) st.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got en=%0b ready=%b data=%0h, expected no strobe", TX_ENABLE, req_ready, TX_DATA);
      end else begin
        e = sb.pop_front();
        chk("strobe_enable", 32'(TX_ENABLE), 1);
        chk("grant_onehot", 32'(req_ready), 32'(1) << e[11:8]);
        chk("tx_data", 32'(TX_DATA), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, n;
    reset_n   = 1'b0;
    TX_READY  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    repeat (3) begin
      @(negedge clock);
      chk("reset_outputs", 32'({busy, TX_ENABLE, req_ready, TX_DATA}), 0);
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clock);
      chk("idle_outputs", 32'({busy, TX_ENABLE, req_ready, TX_DATA}), 0);
    end
`ifndef BAMBU_TX_ARB_LINE_LOCK_EN
    @(posedge clock);
    #1;
    st.delete();
    rq[2].push_back(8'h41);
    rq[2].push_back(8'h42);
    expect_grant(2, 8'h41);
    expect_grant(2, 8'h42);
    drain(60);
    chk("single_count", 32'(st.size()), 2);
    if (st.size() == 2) begin
      chk("single_latency", 32'(st[0] - vcyc[2]), 1);
      chk("single_spacing", 32'(st[1] - st[0]), 3);
    end
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rq[i].push_back(8'h10 + 8'(i));
      rq[i].push_back(8'h20 + 8'(i));
    end
    for (int i = 0; i < NR; i++) expect_grant(i, 8'h10 + 8'(i));
    for (int i = 0; i < NR; i++) expect_grant(i, 8'h20 + 8'(i));
    drain(100);
    chk("rr_count", 32'(st.size()), 8);
    for (int k = 0; k + 1 < st.size(); k++) chk("rr_spacing", 32'(st[k+1] - st[k]), 3);
    @(posedge clock);
    #1;
    st.delete();
    TX_READY = 1'b0;
    rq[1].push_back(8'h55);
    expect_grant(1, 8'h55);
    repeat (10) begin
      @(negedge clock);
      chk("bp_hold", 32'({TX_ENABLE, req_ready}), 0);
    end
    @(posedge clock);
    #1;
    TX_READY = 1'b1;
    r = cyc;
    drain(20);
    chk("bp_count", 32'(st.size()), 1);
    if (st.size() == 1) chk("bp_latency", 32'(st[0] - r), 1);
    @(posedge clock);
    #1;
    rq[3].push_back(8'h77);
    expect_grant(3, 8'h77);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!TX_ENABLE && n < 20);
    chk("mid_strobe_seen", 32'(TX_ENABLE), 1);
    chk("mid_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1 chk("mid_reset_drop", 32'({busy, TX_ENABLE, req_ready, TX_DATA}), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      rq[i].push_back(8'hA0 + 8'(i));
      expect_grant(i, 8'hA0 + 8'(i));
    end
    drain(60);
`else
    do_reset();
    rq[0].push_back(8'h61);
    rq[0].push_back(8'h62);
    rq[0].push_back(8'h0A);
    rq[1].push_back(8'h31);
    expect_grant(0, 8'h61);
    expect_grant(0, 8'h62);
    expect_grant(0, 8'h0A);
    expect_grant(1, 8'h31);
    drain(80);
    chk("lock_line_count", 32'(st.size()), 4);
    do_reset();
    rq[0].push_back(8'h61);
    rq[1].push_back(8'h32);
    expect_grant(0, 8'h61);
    expect_grant(1, 8'h32);
    drain(80);
    chk("lock_timeout_count", 32'(st.size()), 2);
    if (st.size() == 2) chk("lock_timeout_delay", 32'(st[1] - st[0]), 11);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
